// File: rtl/rv2t_machine_timer_pkg.sv
// Shared RV2T machine-timer definitions: register window offsets and reset constants.
package rv2t_machine_timer_pkg;

    typedef enum logic [1:0] {
        MTIMER_MTIME_LO    = 2'd0,
        MTIMER_MTIME_HI    = 2'd1,
        MTIMER_MTIMECMP_LO = 2'd2,
        MTIMER_MTIMECMP_HI = 2'd3
    } mtimer_reg_e;

    // Sized for XLEN up to 64; the timer keeps the low 2*XLEN bits.
    localparam logic [127:0] MTIMER_MTIMECMP_RESET = {128{1'b1}};

    localparam int unsigned MTIMER_PRESCALE_MAX = 65535;
    localparam int unsigned MTIMER_PRESCALE_W   = 16;

endpackage

// File: rtl/rv2t_machine_timer_if.sv
// Register-window bus between the data-memory path and the machine timer.
interface rv2t_machine_timer_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            read_enable;
    logic            write_enable;
    logic [1:0]      addr;
    logic [XLEN-1:0] write_data_in;
    logic            read_en_out;
    logic [XLEN-1:0] read_data_out;

    modport master (
        output read_enable, write_enable, addr, write_data_in,
        input  read_en_out, read_data_out
    );

    modport slave (
        input  read_enable, write_enable, addr, write_data_in,
        output read_en_out, read_data_out
    );
endinterface

// File: rtl/rv2t_machine_timer_prescaler.sv
// Free-running divider: tick is high for one cycle out of every PRESCALE.
module rv2t_timer_prescaler
    import rv2t_machine_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic sync_reset,
    output logic tick
);
    localparam logic [MTIMER_PRESCALE_W-1:0] LAST = MTIMER_PRESCALE_W'(PRESCALE - 1);

    logic [MTIMER_PRESCALE_W-1:0] count;

    // With PRESCALE = 1 the count never leaves zero and tick is permanently high.
    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/rv2t_machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a 32-bit register window.
module rv2t_machine_timer
    import rv2t_machine_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned XLEN     = 32
) (
    input  logic                       clk,
    input  logic                       sync_reset,
    rv2t_machine_timer_if.slave        bus,
    output logic                       timer_triggered
);
    localparam int unsigned TW = 2 * XLEN;

    logic            tick;
    mtimer_reg_e     reg_sel;
    logic [TW-1:0]   mtime;
    logic [TW-1:0]   mtimecmp;
    logic [XLEN-1:0] snap_hi;
    logic            read_valid;
    logic [XLEN-1:0] read_data;

    logic [TW-1:0]   mtime_p0;
    logic [TW-1:0]   mtimecmp_p0;
    logic [XLEN-1:0] snap_hi_p0;
    logic [XLEN-1:0] rdata_p0;
    logic            trig_p0;

    rv2t_timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk        (clk),
        .sync_reset (sync_reset),
        .tick       (tick)
    );

    assign reg_sel = mtimer_reg_e'(bus.addr);

    // A write to either mtime half replaces the increment for that cycle.
    always_comb begin
        mtime_p0    = tick ? mtime + 1'b1 : mtime;
        mtimecmp_p0 = mtimecmp;
        if (bus.write_enable) begin
            case (reg_sel)
                MTIMER_MTIME_LO:    mtime_p0    = {mtime[TW-1:XLEN], bus.write_data_in};
                MTIMER_MTIME_HI:    mtime_p0    = {bus.write_data_in, mtime[XLEN-1:0]};
                MTIMER_MTIMECMP_LO: mtimecmp_p0 = {mtimecmp[TW-1:XLEN], bus.write_data_in};
                MTIMER_MTIMECMP_HI: mtimecmp_p0 = {bus.write_data_in, mtimecmp[XLEN-1:0]};
                default: ;
            endcase
        end
    end

    // Reads see pre-write state; a lo read freezes hi so a later hi read is coherent.
    always_comb begin
        rdata_p0   = '0;
        snap_hi_p0 = snap_hi;
        if (bus.read_enable) begin
            case (reg_sel)
                MTIMER_MTIME_LO: begin
                    rdata_p0   = mtime[XLEN-1:0];
                    snap_hi_p0 = mtime[TW-1:XLEN];
                end
                MTIMER_MTIME_HI:    rdata_p0 = snap_hi;
                MTIMER_MTIMECMP_LO: rdata_p0 = mtimecmp[XLEN-1:0];
                MTIMER_MTIMECMP_HI: rdata_p0 = mtimecmp[TW-1:XLEN];
                default: ;
            endcase
        end
    end

    assign trig_p0 = (mtime_p0 >= mtimecmp_p0);

    // Stage p0 -> registered state and outputs
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            mtime           <= '0;
            mtimecmp        <= MTIMER_MTIMECMP_RESET[TW-1:0];
            snap_hi         <= '0;
            read_valid      <= 1'b0;
            read_data       <= '0;
            timer_triggered <= 1'b0;
        end else begin
            mtime           <= mtime_p0;
            mtimecmp        <= mtimecmp_p0;
            snap_hi         <= snap_hi_p0;
            read_valid      <= bus.read_enable;
            if (bus.read_enable) begin
                read_data <= rdata_p0;
            end
            timer_triggered <= trig_p0;
        end
    end

    assign bus.read_en_out   = read_valid;
    assign bus.read_data_out = read_data;
endmodule

// File: tb/tb_rv2t_machine_timer.sv
// Bench for rv2t_machine_timer: two instances (PRESCALE 1 and 4) against a behavioural model.
module tb_rv2t_machine_timer;

    logic        clk;
    logic        rst;
    logic        re;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        trig_a;
    logic        trig_b;
    bit          chk_en;

    int checks;
    int failures;

    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic [31:0] m_snap [2];
    logic [31:0] m_rd   [2];
    logic        m_ren  [2];
    logic        m_trig [2];
    int          m_cnt  [2];

    rv2t_machine_timer_if #(.XLEN(32)) ifa ();
    rv2t_machine_timer_if #(.XLEN(32)) ifb ();

    assign ifa.read_enable   = re;
    assign ifa.write_enable  = we;
    assign ifa.addr          = addr;
    assign ifa.write_data_in = wd;
    assign ifb.read_enable   = re;
    assign ifb.write_enable  = we;
    assign ifb.addr          = addr;
    assign ifb.write_data_in = wd;

    rv2t_machine_timer #(.PRESCALE(1), .XLEN(32)) dut_a (
        .clk             (clk),
        .sync_reset      (rst),
        .bus             (ifa.slave),
        .timer_triggered (trig_a)
    );

    rv2t_machine_timer #(.PRESCALE(4), .XLEN(32)) dut_b (
        .clk             (clk),
        .sync_reset      (rst),
        .bus             (ifb.slave),
        .timer_triggered (trig_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ps(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Specification-level model of one timer at a clock edge, using the inputs held over that edge.
    task automatic model_edge(input int k);
        logic inc;
        if (rst) begin
            m_time[k] = 64'd0;
            m_cmp[k]  = {64{1'b1}};
            m_snap[k] = 32'd0;
            m_cnt[k]  = 0;
            m_ren[k]  = 1'b0;
            m_rd[k]   = 32'd0;
            m_trig[k] = 1'b0;
        end else begin
            inc      = (m_cnt[k] == ps(k) - 1);
            m_cnt[k] = (m_cnt[k] + 1) % ps(k);
            m_ren[k] = re;
            if (re) begin
                case (addr)
                    2'd0: begin m_rd[k] = m_time[k][31:0]; m_snap[k] = m_time[k][63:32]; end
                    2'd1: m_rd[k] = m_snap[k];
                    2'd2: m_rd[k] = m_cmp[k][31:0];
                    default: m_rd[k] = m_cmp[k][63:32];
                endcase
            end
            if (inc && !(we && addr <= 2'd1)) m_time[k] = m_time[k] + 64'd1;
            if (we) begin
                case (addr)
                    2'd0: m_time[k][31:0]  = wd;
                    2'd1: m_time[k][63:32] = wd;
                    2'd2: m_cmp[k][31:0]   = wd;
                    default: m_cmp[k][63:32] = wd;
                endcase
            end
            m_trig[k] = (m_time[k] >= m_cmp[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
    endtask

    task automatic idle(input int n);
        re = 1'b0;
        we = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        re = 1'b0; we = 1'b1; addr = a; wd = d;
        step();
        we = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] ra, output logic [31:0] rb);
        re = 1'b1; we = 1'b0; addr = a;
        step();
        re = 1'b0;
        ra = ifa.read_data_out;
        rb = ifb.read_data_out;
    endtask

    task automatic do_rw(input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] ra, output logic [31:0] rb);
        re = 1'b1; we = 1'b1; addr = a; wd = d;
        step();
        re = 1'b0; we = 1'b0;
        ra = ifa.read_data_out;
        rb = ifb.read_data_out;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_read_en",   {63'd0, ifa.read_en_out}, {63'd0, m_ren[0]});
            chk("a_read_data", {32'd0, ifa.read_data_out}, {32'd0, m_rd[0]});
            chk("a_trigger",   {63'd0, trig_a}, {63'd0, m_trig[0]});
            chk("b_read_en",   {63'd0, ifb.read_en_out}, {63'd0, m_ren[1]});
            chk("b_read_data", {32'd0, ifb.read_data_out}, {32'd0, m_rd[1]});
            chk("b_trigger",   {63'd0, trig_b}, {63'd0, m_trig[1]});
        end
    end

    initial begin
        logic [31:0] ra, rb, ra2, rb2, old_a, old_b;
        int n;
        checks = 0; failures = 0; chk_en = 1'b0;
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = 2'd0; wd = 32'd0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        idle(13);

        // reset in the middle of counting
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("reset_trig_a", {63'd0, trig_a}, 64'd0);
        chk("reset_trig_b", {63'd0, trig_b}, 64'd0);
        chk("reset_ren_a",  {63'd0, ifa.read_en_out}, 64'd0);
        do_read(2'd0, ra, rb);
        chk("reset_mtime_lo_a", {32'd0, ra}, 64'd0);
        chk("reset_mtime_lo_b", {32'd0, rb}, 64'd0);
        do_read(2'd1, ra, rb);
        chk("reset_mtime_hi_a", {32'd0, ra}, 64'd0);
        do_read(2'd2, ra, rb);
        chk("reset_cmp_lo_a", {32'd0, ra}, 64'h0000_0000_FFFF_FFFF);
        chk("reset_cmp_lo_b", {32'd0, rb}, 64'h0000_0000_FFFF_FFFF);
        do_read(2'd3, ra, rb);
        chk("reset_cmp_hi_a", {32'd0, ra}, 64'h0000_0000_FFFF_FFFF);

        // trigger at mtime == 20 on the PRESCALE=1 timer
        do_write(2'd3, 32'd0);
        do_write(2'd2, 32'd20);
        do_write(2'd0, 32'd0);
        idle(19);
        chk("trig_before_20", {63'd0, trig_a}, 64'd0);
        idle(1);
        chk("trig_at_20", {63'd0, trig_a}, 64'd1);
        chk("model_trig_at_20", {63'd0, m_trig[0]}, 64'd1);
        chk("model_mtime_at_20", m_time[0], 64'd20);
        do_write(2'd2, 32'hFFFF_FFFF);
        chk("trig_deassert", {63'd0, trig_a}, 64'd0);

        // coherent lo/hi read across a carry
        do_write(2'd0, 32'hFFFF_FFFE);
        do_write(2'd1, 32'd0);
        do_read(2'd0, ra, rb);
        chk("carry_lo", {32'd0, ra}, 64'h0000_0000_FFFF_FFFE);
        idle(5);
        do_read(2'd1, ra, rb);
        chk("carry_hi_snapshot", {32'd0, ra}, 64'd0);
        do_read(2'd0, ra, rb);
        chk("carry_fresh_lo", {32'd0, ra}, 64'd5);
        do_read(2'd1, ra, rb);
        chk("carry_fresh_hi", {32'd0, ra}, 64'd1);

        // prescaler spacing over 40 cycles
        do_read(2'd0, ra, rb);
        idle(39);
        do_read(2'd0, ra2, rb2);
        chk("prescale4_delta", {32'd0, rb2 - rb}, 64'd10);
        chk("prescale1_delta", {32'd0, ra2 - ra}, 64'd40);

        // write mtime_lo on a tick cycle of the PRESCALE=4 timer
        n = 0;
        while (m_cnt[1] != 3 && n < 8) begin
            step();
            n++;
        end
        chk("tick_align_bound", {63'd0, (n < 8)}, 64'd1);
        old_a = m_time[0][31:0];
        old_b = m_time[1][31:0];
        do_rw(2'd0, 32'd100, ra, rb);
        chk("collide_old_a", {32'd0, ra}, {32'd0, old_a});
        chk("collide_old_b", {32'd0, rb}, {32'd0, old_b});
        idle(7);
        do_read(2'd0, ra, rb);
        chk("collide_after_a", {32'd0, ra}, 64'd107);
        chk("collide_after_b", {32'd0, rb}, 64'd101);

        // 64-bit wrap with mtimecmp = 0
        do_write(2'd2, 32'd0);
        do_write(2'd3, 32'd0);
        do_write(2'd0, 32'hFFFF_FFFF);
        do_write(2'd1, 32'hFFFF_FFFF);
        chk("wrap_trig_max", {63'd0, trig_a}, 64'd1);
        do_read(2'd0, ra, rb);
        chk("wrap_lo_max", {32'd0, ra}, 64'h0000_0000_FFFF_FFFF);
        chk("wrap_trig_zero", {63'd0, trig_a}, 64'd1);
        chk("model_wrap_zero", m_time[0], 64'd0);
        do_read(2'd1, ra, rb);
        chk("wrap_hi_snapshot", {32'd0, ra}, 64'h0000_0000_FFFF_FFFF);
        do_read(2'd0, ra, rb);
        chk("wrap_lo_after", {32'd0, ra}, 64'd1);
        do_read(2'd1, ra, rb);
        chk("wrap_hi_after", {32'd0, ra}, 64'd0);
        chk("wrap_trig_after", {63'd0, trig_a}, 64'd1);

        // randomized traffic, including resets that collide with accesses
        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            re   = ($urandom_range(0, 2) == 0);
            we   = ($urandom_range(0, 3) == 0);
            addr = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: wd = 32'd0;
                1: wd = 32'hFFFF_FFFF;
                2: wd = 32'($urandom_range(0, 40));
                default: wd = $urandom;
            endcase
            step();
        end
        rst = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
